// File: rtl/dcache_ctrl.sv
// Blocking write-back controller for a direct-mapped, one-word-per-line data cache.
// Misses write back a dirty victim, refill the line from memory, then replay the lookup.
module dcache_ctrl #(
  parameter int unsigned LINE_SIZE  = 4,
  parameter int unsigned CACHE_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] cache_addr,
  input  logic        cache_hit,
  input  logic        cache_dirty,
  input  logic [31:0] cache_data,
  input  logic [31:0] cache_victim_addr,
  output logic [31:0] cache_wdata,
  output logic [3:0]  cache_wstrb,
  output logic        cache_wvalid,
  output logic        cache_waccess,
  output logic        mem_awvalid,
  input  logic        mem_awready,
  output logic [31:0] mem_awaddr,
  output logic [31:0] mem_wdata,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  // Byte offset within a line; the capacity term keeps the mask inside the array.
  localparam logic [AW-1:0] OFF_MASK = AW'(LINE_SIZE - 1) & AW'(CACHE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_STORE, S_WB, S_AR, S_R, S_FILL
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  // State and request-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and next-context logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_CHECK;
      S_CHECK: begin
        // Dirty only matters for the victim of a miss.
        if (cache_hit) begin
          if (write_q) begin
            state_d = S_STORE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cache_data;
            state_d     = S_IDLE;
          end
        end else if (cache_dirty) begin
          state_d = S_WB;
        end else begin
          state_d = S_AR;
        end
      end
      S_STORE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_WB: if (mem_awready) state_d = S_AR;
      S_AR: if (mem_arready) state_d = S_R;
      S_R: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_FILL;
        end
      end
      S_FILL:  state_d = S_LOOKUP;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    req_ready     = 1'b0;
    cache_addr    = addr_q;
    cache_wdata   = '0;
    cache_wstrb   = '0;
    cache_wvalid  = 1'b0;
    cache_waccess = 1'b0;
    mem_awvalid   = 1'b0;
    mem_awaddr    = '0;
    mem_wdata     = '0;
    mem_arvalid   = 1'b0;
    mem_araddr    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready  = 1'b1;
        cache_addr = req_addr;
      end
      S_STORE: begin
        // Array keeps bytes whose strobe bit is set, so the CPU strobe is inverted.
        cache_wvalid  = 1'b1;
        cache_waccess = 1'b1;
        cache_wdata   = wdata_q;
        cache_wstrb   = ~wstrb_q;
      end
      S_WB: begin
        mem_awvalid = 1'b1;
        mem_awaddr  = cache_victim_addr & ~OFF_MASK;
        mem_wdata   = cache_data;
      end
      S_AR: begin
        mem_arvalid = 1'b1;
        mem_araddr  = addr_q & ~OFF_MASK;
      end
      S_FILL: begin
        cache_wvalid = 1'b1;
        cache_wdata  = rdata_q;
        cache_wstrb  = '1;
      end
      default: ;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 4: line size in bytes; only 4 (one 32-bit word per line) is supported.
REQ-002 SHALL have parameter CACHE_SIZE, default 1024: array capacity in bytes; it is informational only.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req_valid/req_ready, input/output, 1 each: CPU request handshake.
REQ-006 SHALL have port req_addr, input, 32: CPU byte address.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_wdata/req_wstrb, input, 32/4: store data and byte strobe.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 32: load data, valid while rsp_valid=1.
REQ-011 SHALL have ports cache_addr (output, 32), cache_hit/cache_dirty (input, 1 each), cache_data (input, 32), cache_victim_addr (input, 32), cache_wdata (output, 32), cache_wstrb (output, 4), cache_wvalid (output, 1), cache_waccess (output, 1): cache array port, 1-cycle registered read latency.
REQ-012 SHALL have ports mem_awvalid/mem_awready, mem_awaddr (32), mem_wdata (32): memory write; address and data are transferred together.
REQ-013 SHALL have ports mem_arvalid/mem_arready, mem_araddr (32), mem_rvalid (input, 1), mem_rdata (32): memory read; the controller is always ready for read data.

Function
REQ-014 SHALL implement states IDLE, LOOKUP, CHECK, STORE, WB, AR, R, FILL.
REQ-015 SHALL assert req_ready only in IDLE, latching addr/write/wdata/wstrb on req_valid&&req_ready and moving to LOOKUP.
REQ-016 SHALL drive cache_addr from the latched address in every non-IDLE state, and from req_addr in IDLE.
REQ-017 SHALL move LOOKUP->CHECK unconditionally, giving the array one cycle of read latency.
REQ-018 SHALL, in CHECK with hit and load: pulse rsp_valid with rsp_rdata=cache_data, then go to IDLE (load hit = 3 cycles from handshake to rsp_valid).
REQ-019 SHALL, in CHECK with hit and store: go to STORE.
REQ-020 SHALL, in STORE: assert cache_wvalid=1, cache_waccess=1, cache_wdata=latched wdata, cache_wstrb=~latched wstrb (the array keeps bytes whose strobe bit is 1); pulse rsp_valid; go to IDLE.
REQ-021 SHALL, in CHECK with miss and dirty: go to WB; on miss and clean: go to AR.
REQ-022 SHALL, in WB: hold mem_awvalid=1, mem_awaddr=cache_victim_addr & ~3, mem_wdata=cache_data stable until mem_awready, then go to AR.
REQ-023 SHALL, in AR: hold mem_arvalid=1, mem_araddr=latched addr & ~3 until mem_arready, then go to R.
REQ-024 SHALL, in R: capture mem_rdata on mem_rvalid and go to FILL; rvalid outside R is ignored.
REQ-025 SHALL, in FILL: assert cache_wvalid=1, cache_waccess=0, cache_wdata=captured rdata, cache_wstrb=4'hF, then go to LOOKUP (the replay then hits).
REQ-026 SHALL drive cache_wvalid, mem_awvalid, mem_arvalid and rsp_valid to 0 in every state not listed above.
REQ-027 SHALL accept no new request until rsp_valid has pulsed; a req_valid held across a busy period is accepted in the first IDLE cycle.
REQ-028 SHALL treat cache_hit=1 together with cache_dirty=1 as a hit; dirty is ignored on a hit.

Reset
REQ-029 SHALL, while rst_n=0: state=IDLE; rsp_valid, rsp_rdata, cache_wvalid, cache_waccess, cache_wdata, cache_wstrb, mem_awvalid, mem_arvalid, latched fields=0; req_ready=1 after release.
REQ-030 SHALL abandon any outstanding memory transaction when reset is asserted mid-operation, with no rsp_valid issued for it.

Verification
REQ-031 SHALL verify load hit: load 0x100 with hit=1, cache_data=0xDEADBEEF -> rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, no mem traffic.
REQ-032 SHALL verify store hit: store 0x104, wdata=0x11223344, wstrb=0x3 -> single STORE cycle with cache_wvalid=1, waccess=1, cache_wstrb=0xC, then rsp_valid.
REQ-033 SHALL verify clean miss: load 0x200 with miss, clean, mem returning 0xCAFEF00D after 3 stall cycles -> araddr=0x200, FILL writes 0xCAFEF00D with strb 0xF, then rsp_rdata=0xCAFEF00D.
REQ-034 SHALL verify dirty miss: victim_addr=0x1200, data=0xAAAA5555 -> awaddr=0x1200, wdata=0xAAAA5555 held for 4 cycles until awready, then a read of 0x200; no read is issued before awready.
REQ-035 SHALL verify back-to-back requests: req_valid held high for two loads -> the second is accepted only in the IDLE cycle after the first rsp_valid.
REQ-036 SHALL verify reset in R state: rst_n low for 1 cycle -> all valids 0, state IDLE, no rsp_valid, and a late mem_rvalid is ignored.
